aes_controller_output: RTL and testbench

//  Bus-independent AES controller output block; reverse of the controller input path.

---
 rtl/aes_controller_output_pkg.sv | 27 ++
 rtl/aes_controller_output_fifo.sv | 71 +++++++
 rtl/aes_controller_output.sv | 145 ++++++++++++++
 tb/tb_aes_controller_output.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_controller_output_pkg.sv
// ---------------------------------------------------------------------------
// aes_controller_output_pkg
//   Shared AES sizing constants, serialiser state type and the byte-swap
//   helper used by the controller output block.
//   BLK_S        : AES block width in bits
//   WORD_S       : output bus word width in bits
//   NB           : number of bus words per AES block
//   OUT_LAST_BIT : bit index of the packet-last flag in a FIFO entry
// ---------------------------------------------------------------------------
package aes_controller_output_pkg;

   localparam int BLK_S        = 128;
   localparam int WORD_S       = 32;
   localparam int NB           = 4;
   localparam int OUT_LAST_BIT = BLK_S;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // Reverses byte order of one bus word for big-endian sinks.
   function automatic logic [WORD_S-1:0] byteswap32(input logic [WORD_S-1:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_controller_output_fifo.sv
// ---------------------------------------------------------------------------
// aes_controller_output_fifo
//   First-word-fall-through block FIFO with a synchronous clear.
//   Status flags are decoded from the registered occupancy count, so a write
//   presented while full is refused even if a pop happens in the same cycle.
// Ports:
//   clk            in   clock
//   rst            in   synchronous clear, active-high
//   i_wr_en        in   write request (ignored while full)
//   i_wr_data      in   write entry
//   i_rd_en        in   pop request (ignored while empty)
//   o_rd_data      out  head entry (valid while !o_empty)
//   o_full         out  DEPTH entries held
//   o_almost_full  out  DEPTH-1 entries held
//   o_empty        out  no entries held
// ---------------------------------------------------------------------------
module aes_controller_output_fifo #(
   parameter int DATA_WIDTH = 129,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_wr_en,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_full,
   output logic                  o_almost_full,
   output logic                  o_empty
);

   localparam logic [ADDR_WIDTH:0] FULL_CNT  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH+1)'(DEPTH-1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  w_wr;
   logic                  w_rd;

   assign o_full        = (r_count == FULL_CNT);
   assign o_almost_full = (r_count == AFULL_CNT);
   assign o_empty       = (r_count == '0);
   assign w_wr          = i_wr_en && !o_full;
   assign w_rd          = i_rd_en && !o_empty;
   assign o_rd_data     = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
            2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; occupancy alone defines what is valid.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

endmodule

// File: rtl/aes_controller_output.sv
// ---------------------------------------------------------------------------
// aes_controller_output
//   Buffers 128-bit AES result blocks in a FIFO and serialises each block as
//   four 32-bit words (word0 = bits [31:0] first) on a valid/ready stream.
//   bus_tlast marks word 3 of a block that was written with out_fifo_wlast.
//   Optional build macro AES_CONTROLLER_OUTPUT_BYTESWAP_EN byte-reverses each
//   output word for big-endian sinks; handshake and timing are unchanged.
// Ports:
//   clk                    in   clock
//   reset_n                in   asynchronous reset, active-low
//   out_fifo_write_tvalid  in   result block valid
//   out_fifo_write_tready  out  FIFO can accept a block
//   out_fifo_wdata         in   result block
//   out_fifo_wlast         in   block is last of packet
//   out_fifo_almost_full   out  FIFO holds FIFO_SIZE-1 blocks
//   out_fifo_empty         out  FIFO holds no blocks
//   bus_tvalid             out  output word valid
//   bus_tready             in   sink accepts word
//   bus_tdata              out  output word
//   bus_tlast              out  last word of packet
//   controller_out_busy    out  serialiser holds a block or FIFO not empty
// ---------------------------------------------------------------------------
module aes_controller_output
   import aes_controller_output_pkg::*;
#(
   parameter int BUS_DATA_WIDTH  = 32,
   parameter int FIFO_SIZE       = 16,
   parameter int FIFO_ADDR_WIDTH = 4,
   parameter int FIFO_DATA_WIDTH = 128
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      out_fifo_write_tvalid,
   output logic                      out_fifo_write_tready,
   input  logic [FIFO_DATA_WIDTH-1:0] out_fifo_wdata,
   input  logic                      out_fifo_wlast,
   output logic                      out_fifo_almost_full,
   output logic                      out_fifo_empty,
   output logic                      bus_tvalid,
   input  logic                      bus_tready,
   output logic [BUS_DATA_WIDTH-1:0] bus_tdata,
   output logic                      bus_tlast,
   output logic                      controller_out_busy
);

   localparam logic [1:0] LAST_WORD = 2'(NB-1);

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [FIFO_DATA_WIDTH-1:0] r_blk;
   logic                       r_last;
   logic [1:0]                 r_word_cnt;

   logic                       w_fifo_rst;
   logic                       w_fifo_full;
   logic                       w_fifo_wr;
   logic                       w_pop;
   logic                       w_shift;
   logic                       w_xfer;
   logic [FIFO_DATA_WIDTH:0]   w_fifo_rdata;
   logic [BUS_DATA_WIDTH-1:0]  w_word;

   assign w_fifo_rst            = !reset_n;
   assign out_fifo_write_tready = !w_fifo_full && reset_n;
   assign w_fifo_wr             = out_fifo_write_tvalid && out_fifo_write_tready;

   aes_controller_output_fifo #(
      .DATA_WIDTH (FIFO_DATA_WIDTH + 1),
      .DEPTH      (FIFO_SIZE),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_fifo (
      .clk           (clk),
      .rst           (w_fifo_rst),
      .i_wr_en       (w_fifo_wr),
      .i_wr_data     ({out_fifo_wlast, out_fifo_wdata}),
      .i_rd_en       (w_pop),
      .o_rd_data     (w_fifo_rdata),
      .o_full        (w_fifo_full),
      .o_almost_full (out_fifo_almost_full),
      .o_empty       (out_fifo_empty)
   );

   assign bus_tvalid          = (r_state == ST_SEND);
   assign w_xfer              = bus_tvalid && bus_tready;
   assign bus_tlast           = bus_tvalid && r_last && (r_word_cnt == LAST_WORD);
   assign controller_out_busy = bus_tvalid || !out_fifo_empty;
   assign w_word              = r_blk[BUS_DATA_WIDTH-1:0];

`ifdef AES_CONTROLLER_OUTPUT_BYTESWAP_EN
   assign bus_tdata = byteswap32(w_word);
`else
   assign bus_tdata = w_word;
`endif

   // Next state: a pop always reloads the shift register; otherwise each
   // transfer shifts out one word (including word 3 on the way to IDLE).
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_shift     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!out_fifo_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (w_xfer) begin
               if (r_word_cnt == LAST_WORD && !out_fifo_empty) begin
                  w_pop = 1'b1;
               end else begin
                  w_shift = 1'b1;
                  if (r_word_cnt == LAST_WORD) w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_blk      <= '0;
         r_last     <= 1'b0;
         r_word_cnt <= '0;
      end else if (w_pop) begin
         r_blk      <= w_fifo_rdata[FIFO_DATA_WIDTH-1:0];
         r_last     <= w_fifo_rdata[OUT_LAST_BIT];
         r_word_cnt <= '0;
      end else if (w_shift) begin
         r_blk      <= r_blk >> BUS_DATA_WIDTH;
         r_word_cnt <= r_word_cnt + 2'd1;
      end
   end

endmodule

// File: tb/tb_aes_controller_output.sv
module tb_aes_controller_output;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         out_fifo_write_tvalid;
   logic         out_fifo_write_tready;
   logic [127:0] out_fifo_wdata;
   logic         out_fifo_wlast;
   logic         out_fifo_almost_full;
   logic         out_fifo_empty;
   logic         bus_tvalid;
   logic         bus_tready;
   logic [31:0]  bus_tdata;
   logic         bus_tlast;
   logic         controller_out_busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [32:0] exp_q[$];
   int          run_len   = 0;
   int          max_run   = 0;
   int          tlast_cnt = 0;
   bit          stall_prev = 0;
   logic [31:0] prev_data;
   logic        prev_last;

   localparam logic [127:0] BLK_A = 128'h33333333_22222222_11111111_00000000;
   localparam logic [127:0] BLK_D = 128'h0f0e0d0c_0b0a0908_07060504_03020100;

   always #5 clk = ~clk;

   aes_controller_output dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .out_fifo_write_tvalid (out_fifo_write_tvalid),
      .out_fifo_write_tready (out_fifo_write_tready),
      .out_fifo_wdata        (out_fifo_wdata),
      .out_fifo_wlast        (out_fifo_wlast),
      .out_fifo_almost_full  (out_fifo_almost_full),
      .out_fifo_empty        (out_fifo_empty),
      .bus_tvalid            (bus_tvalid),
      .bus_tready            (bus_tready),
      .bus_tdata             (bus_tdata),
      .bus_tlast             (bus_tlast),
      .controller_out_busy   (controller_out_busy)
   );

   function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef AES_CONTROLLER_OUTPUT_BYTESWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every bus transfer.
   always @(negedge clk) begin
      if (!reset_n) begin
         stall_prev = 0;
         run_len    = 0;
      end else begin
         if (stall_prev) begin
            chk("hold_tvalid", 128'(bus_tvalid), 128'd1);
            chk("hold_data", {95'd0, bus_tlast, bus_tdata}, {95'd0, prev_last, prev_data});
         end
         if (bus_tvalid && bus_tready) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (bus_tlast) tlast_cnt++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_word: got %0h expected none", bus_tdata);
            end else begin
               chk("word", {95'd0, bus_tlast, bus_tdata}, {95'd0, exp_q.pop_front()});
            end
         end else begin
            run_len = 0;
         end
         stall_prev = bus_tvalid && !bus_tready;
         prev_data  = bus_tdata;
         prev_last  = bus_tlast;
      end
   end

   task automatic write_block(input logic [127:0] d, input logic l);
      int k = 0;
      @(negedge clk);
      while (!out_fifo_write_tready && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (!out_fifo_write_tready) begin
         chk("write_timeout", 128'(out_fifo_write_tready), 128'd1);
         return;
      end
      out_fifo_write_tvalid = 1'b1;
      out_fifo_wdata        = d;
      out_fifo_wlast        = l;
      @(posedge clk);
      for (int i = 0; i < 4; i++) exp_q.push_back({l && (i == 3), exp_word(d[32*i +: 32])});
      #1 out_fifo_write_tvalid = 1'b0;
   endtask

   task automatic wait_tvalid();
      int k = 0;
      @(negedge clk);
      while (!bus_tvalid && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("wait_tvalid", 128'(bus_tvalid), 128'd1);
   endtask

   task automatic drain();
      int k = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || controller_out_busy) && k < 1000) begin
         @(negedge clk);
         k++;
      end
      chk("drain_queue", 128'(exp_q.size()), 128'd0);
      chk("drain_tvalid", 128'(bus_tvalid), 128'd0);
   endtask

   task automatic clr_stats();
      max_run   = 0;
      tlast_cnt = 0;
   endtask

   initial begin
      reset_n               = 1'b1;
      out_fifo_write_tvalid = 1'b0;
      out_fifo_wdata        = '0;
      out_fifo_wlast        = 1'b0;
      bus_tready            = 1'b0;
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tvalid", 128'(bus_tvalid), 128'd0);
      chk("rst_tlast", 128'(bus_tlast), 128'd0);
      chk("rst_tdata", 128'(bus_tdata), 128'd0);
      chk("rst_wready", 128'(out_fifo_write_tready), 128'd0);
      chk("rst_empty", 128'(out_fifo_empty), 128'd1);
      chk("rst_busy", 128'(controller_out_busy), 128'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_wready", 128'(out_fifo_write_tready), 128'd1);

      // Single block, sink always ready; first tvalid one edge after the FIFO write.
      clr_stats();
      bus_tready = 1'b1;
      write_block(BLK_A, 1'b1);
      chk("latency_early", 128'(bus_tvalid), 128'd0);
      @(posedge clk);
      #1 chk("latency_valid", 128'(bus_tvalid), 128'd1);
      chk("latency_word0", 128'(bus_tdata), 128'(exp_word(32'h00000000)));
      drain();
      chk("single_run", 128'(max_run), 128'd4);
      chk("single_tlast", 128'(tlast_cnt), 128'd1);

      // Back-to-back: three blocks queued, then released with no bubble.
      clr_stats();
      bus_tready = 1'b0;
      write_block(128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 1'b0);
      write_block(128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, 1'b0);
      write_block(128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0, 1'b1);
      @(negedge clk);
      bus_tready = 1'b1;
      drain();
      chk("b2b_run", 128'(max_run), 128'd12);
      chk("b2b_tlast", 128'(tlast_cnt), 128'd1);

      // Backpressure during word 1.
      bus_tready = 1'b0;
      write_block(BLK_A, 1'b1);
      wait_tvalid();
      bus_tready = 1'b1;
      @(posedge clk);
      #1 bus_tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_tvalid", 128'(bus_tvalid), 128'd1);
         chk("bp_tdata", 128'(bus_tdata), 128'(exp_word(32'h11111111)));
      end
      bus_tready = 1'b1;
      drain();

      // Full FIFO: one block parked in the serialiser, then 16 fill the FIFO.
      bus_tready = 1'b0;
      write_block(128'h0, 1'b0);
      wait_tvalid();
      chk("full_pre_empty", 128'(out_fifo_empty), 128'd1);
      for (int i = 1; i <= 16; i++) begin
         write_block({4{i[7:0], 24'h00F1F0}}, (i == 16) ? 1'b1 : 1'b0);
         if (i == 14) chk("afull_14", 128'(out_fifo_almost_full), 128'd0);
         if (i == 15) begin
            chk("afull_15", 128'(out_fifo_almost_full), 128'd1);
            chk("wready_15", 128'(out_fifo_write_tready), 128'd1);
         end
      end
      chk("wready_16", 128'(out_fifo_write_tready), 128'd0);
      chk("afull_16", 128'(out_fifo_almost_full), 128'd0);
      @(negedge clk);
      out_fifo_write_tvalid = 1'b1;
      out_fifo_wdata        = 128'hEEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB;
      out_fifo_wlast        = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 chk("wready_17_refused", 128'(out_fifo_write_tready), 128'd0);
      end
      out_fifo_write_tvalid = 1'b0;
      bus_tready = 1'b1;
      write_block(128'hEEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB, 1'b1);
      drain();

      // Reset mid-block after word 1.
      bus_tready = 1'b0;
      write_block(BLK_A, 1'b1);
      write_block(BLK_D, 1'b0);
      wait_tvalid();
      bus_tready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      bus_tready = 1'b0;
      reset_n    = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_tvalid", 128'(bus_tvalid), 128'd0);
      chk("mid_rst_tlast", 128'(bus_tlast), 128'd0);
      chk("mid_rst_tdata", 128'(bus_tdata), 128'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("mid_rst_empty", 128'(out_fifo_empty), 128'd1);
      chk("mid_rst_busy", 128'(controller_out_busy), 128'd0);
      chk("mid_rst_wready", 128'(out_fifo_write_tready), 128'd0);
      reset_n    = 1'b1;
      bus_tready = 1'b1;
      write_block(BLK_A, 1'b1);
      drain();

      // Byte order of the first word.
      bus_tready = 1'b0;
      write_block(BLK_D, 1'b1);
      wait_tvalid();
`ifdef AES_CONTROLLER_OUTPUT_BYTESWAP_EN
      chk("byteswap_word0", 128'(bus_tdata), 128'h00010203);
`else
      chk("byteswap_word0", 128'(bus_tdata), 128'h03020100);
`endif
      bus_tready = 1'b1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
